// File: rtl/vscale_md_pkg.sv
// Shared encodings for the multiply/divide issue path: MD request fields,
// RV32M funct3 values and the issue controller state.
package vscale_md_pkg;

    localparam int MD_OP_WIDTH      = 2;
    localparam int MD_OUT_SEL_WIDTH = 2;

    localparam logic [MD_OP_WIDTH-1:0] MD_OP_MUL = 2'd0;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_DIV = 2'd1;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_REM = 2'd2;

    localparam logic [MD_OUT_SEL_WIDTH-1:0] MD_OUT_LO  = 2'd0;
    localparam logic [MD_OUT_SEL_WIDTH-1:0] MD_OUT_HI  = 2'd1;
    localparam logic [MD_OUT_SEL_WIDTH-1:0] MD_OUT_REM = 2'd2;

    localparam logic [2:0] RV32_FUNCT3_MUL    = 3'd0;
    localparam logic [2:0] RV32_FUNCT3_MULH   = 3'd1;
    localparam logic [2:0] RV32_FUNCT3_MULHSU = 3'd2;
    localparam logic [2:0] RV32_FUNCT3_MULHU  = 3'd3;
    localparam logic [2:0] RV32_FUNCT3_DIV    = 3'd4;
    localparam logic [2:0] RV32_FUNCT3_DIVU   = 3'd5;
    localparam logic [2:0] RV32_FUNCT3_REM    = 3'd6;
    localparam logic [2:0] RV32_FUNCT3_REMU   = 3'd7;

    typedef enum logic [2:0] {
        MD_IDLE  = 3'd0,
        MD_ISSUE = 3'd1,
        MD_WAIT  = 3'd2,
        MD_WB    = 3'd3,
        MD_DRAIN = 3'd4
    } md_state_e;

endpackage

// File: rtl/vscale_md_decode.sv
// Combinational RV32M funct3 decoder: MD op, result select and operand signedness.
module vscale_md_decode
    import vscale_md_pkg::*;
(
    input  logic [2:0]                  funct3_i,
    output logic [MD_OP_WIDTH-1:0]      op_o,
    output logic [MD_OUT_SEL_WIDTH-1:0] out_sel_o,
    output logic                        in_1_signed_o,
    output logic                        in_2_signed_o
);

    always_comb begin
        op_o          = MD_OP_MUL;
        out_sel_o     = MD_OUT_LO;
        in_1_signed_o = 1'b0;
        in_2_signed_o = 1'b0;
        case (funct3_i)
            RV32_FUNCT3_MUL: begin
                op_o      = MD_OP_MUL;
                out_sel_o = MD_OUT_LO;
            end
            RV32_FUNCT3_MULH: begin
                op_o          = MD_OP_MUL;
                out_sel_o     = MD_OUT_HI;
                in_1_signed_o = 1'b1;
                in_2_signed_o = 1'b1;
            end
            RV32_FUNCT3_MULHSU: begin
                op_o          = MD_OP_MUL;
                out_sel_o     = MD_OUT_HI;
                in_1_signed_o = 1'b1;
            end
            RV32_FUNCT3_MULHU: begin
                op_o      = MD_OP_MUL;
                out_sel_o = MD_OUT_HI;
            end
            RV32_FUNCT3_DIV: begin
                op_o          = MD_OP_DIV;
                out_sel_o     = MD_OUT_LO;
                in_1_signed_o = 1'b1;
                in_2_signed_o = 1'b1;
            end
            RV32_FUNCT3_DIVU: begin
                op_o      = MD_OP_DIV;
                out_sel_o = MD_OUT_LO;
            end
            RV32_FUNCT3_REM: begin
                op_o          = MD_OP_REM;
                out_sel_o     = MD_OUT_REM;
                in_1_signed_o = 1'b1;
                in_2_signed_o = 1'b1;
            end
            default: begin
                op_o      = MD_OP_REM;
                out_sel_o = MD_OUT_REM;
            end
        endcase
    end

endmodule

// File: rtl/vscale_md_issue.sv
// Issue/retire controller between execute and the multi-cycle MD unit.
// Request handshake: a transfer occurs on a rising edge where md_req_valid && md_req_ready; fields are held while valid is up.
module vscale_md_issue
    import vscale_md_pkg::*;
#(
    parameter int XPR_LEN = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        dx_valid,
    input  logic [2:0]                  dx_funct3,
    input  logic [XPR_LEN-1:0]          dx_rs1_data,
    input  logic [XPR_LEN-1:0]          dx_rs2_data,
    input  logic [4:0]                  dx_rd,
    input  logic                        kill,
    output logic                        stall_out,
    output logic                        md_req_valid,
    input  logic                        md_req_ready,
    output logic                        md_req_in_1_signed,
    output logic                        md_req_in_2_signed,
    output logic [MD_OP_WIDTH-1:0]      md_req_op,
    output logic [MD_OUT_SEL_WIDTH-1:0] md_req_out_sel,
    output logic [XPR_LEN-1:0]          md_req_in_1,
    output logic [XPR_LEN-1:0]          md_req_in_2,
    input  logic                        md_resp_valid,
    input  logic [XPR_LEN-1:0]          md_resp_result,
    output logic                        wb_valid,
    output logic [4:0]                  wb_rd,
    output logic [XPR_LEN-1:0]          wb_data,
    input  logic                        wb_ready,
    output md_state_e                   dbg_state
);

    md_state_e                   state_q, state_d;
    logic [MD_OP_WIDTH-1:0]      op_q, dec_op;
    logic [MD_OUT_SEL_WIDTH-1:0] sel_q, dec_sel;
    logic                        s1_q, s2_q, dec_s1, dec_s2;
    logic [XPR_LEN-1:0]          in_1_q, in_2_q, wb_data_q;
    logic [4:0]                  rd_q;
    logic                        latch, capture;

    vscale_md_decode u_decode (
        .funct3_i      (dx_funct3),
        .op_o          (dec_op),
        .out_sel_o     (dec_sel),
        .in_1_signed_o (dec_s1),
        .in_2_signed_o (dec_s2)
    );

    always_comb begin
        state_d      = state_q;
        latch        = 1'b0;
        capture      = 1'b0;
        stall_out    = 1'b0;
        md_req_valid = 1'b0;
        wb_valid     = 1'b0;
        case (state_q)
            MD_IDLE: begin
                stall_out = dx_valid && !kill;
                if (dx_valid && !kill) begin
                    latch   = 1'b1;
                    state_d = MD_ISSUE;
                end
            end
            MD_ISSUE: begin
                stall_out    = 1'b1;
                md_req_valid = 1'b1;
                // A kill that coincides with the transfer leaves the MD unit busy, so it must be drained.
                if (kill) state_d = md_req_ready ? MD_DRAIN : MD_IDLE;
                else if (md_req_ready) state_d = MD_WAIT;
            end
            MD_WAIT: begin
                stall_out = 1'b1;
                if (kill) begin
                    state_d = md_resp_valid ? MD_IDLE : MD_DRAIN;
                end else if (md_resp_valid) begin
                    capture = 1'b1;
                    state_d = MD_WB;
                end
            end
            MD_DRAIN: begin
                stall_out = 1'b1;
                if (md_resp_valid) state_d = MD_IDLE;
            end
            MD_WB: begin
                wb_valid  = 1'b1;
                stall_out = !wb_ready;
                if (kill || wb_ready) state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= MD_IDLE;
            op_q      <= '0;
            sel_q     <= '0;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            in_1_q    <= '0;
            in_2_q    <= '0;
            rd_q      <= '0;
            wb_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (latch) begin
                op_q   <= dec_op;
                sel_q  <= dec_sel;
                s1_q   <= dec_s1;
                s2_q   <= dec_s2;
                in_1_q <= dx_rs1_data;
                in_2_q <= dx_rs2_data;
                rd_q   <= dx_rd;
            end
            if (capture) wb_data_q <= md_resp_result;
        end
    end

    assign md_req_op          = op_q;
    assign md_req_out_sel     = sel_q;
    assign md_req_in_1_signed = s1_q;
    assign md_req_in_2_signed = s2_q;
    assign md_req_in_1        = in_1_q;
    assign md_req_in_2        = in_2_q;
    assign wb_rd              = rd_q;
    assign wb_data            = wb_data_q;
    assign dbg_state          = state_q;

endmodule

// File: doc/vscale_md_issue.md
Name: vscale_md_issue

Overview:
- Issue/retire controller between the execute stage and the multi-cycle multiply/divide unit.
- Decodes RV32M funct3 into MD op, output select and operand signedness, and latches the operands.
- Drives the MD request handshake, stalls the pipeline, captures the one-cycle MD response and presents it to writeback with backpressure.
- Handles kill of the in-flight instruction, including draining an already-issued MD operation.

Parameters:
- XPR_LEN, 32, datapath width.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- dx_valid  in  1  M-extension instruction valid in execute
- dx_funct3  in  3  instruction funct3
- dx_rs1_data  in  XPR_LEN  operand 1
- dx_rs2_data  in  XPR_LEN  operand 2
- dx_rd  in  5  destination register
- kill  in  1  flush the current or in-flight M instruction
- stall_out  out  1  hold the execute stage
- md_req_valid  out  1  request to MD unit
- md_req_ready  in  1  MD unit idle
- md_req_in_1_signed  out  1  operand 1 signed
- md_req_in_2_signed  out  1  operand 2 signed
- md_req_op  out  MD_OP_WIDTH  MUL/DIV/REM
- md_req_out_sel  out  MD_OUT_SEL_WIDTH  LO/HI/REM
- md_req_in_1  out  XPR_LEN  latched operand 1
- md_req_in_2  out  XPR_LEN  latched operand 2
- md_resp_valid  in  1  single-cycle result strobe
- md_resp_result  in  XPR_LEN  result
- wb_valid  out  1  result available for writeback
- wb_rd  out  5  destination register
- wb_data  out  XPR_LEN  result
- wb_ready  in  1  writeback accepts

Behaviour:
- Reset: clk rising edge; reset synchronous, active-high. Forces state IDLE; all outputs 0, stall_out 0.
- States: IDLE, ISSUE, WAIT, WB, DRAIN.
- IDLE:
  - On dx_valid && !kill: latch rs1, rs2, rd and decoded fields; go to ISSUE.
  - stall_out = dx_valid && !kill, combinationally.
- Decode (funct3 -> op, out_sel, s1, s2):
  - 000 MUL, LO, 0, 0
  - 001 MUL, HI, 1, 1
  - 010 MUL, HI, 1, 0
  - 011 MUL, HI, 0, 0
  - 100 DIV, LO, 1, 1
  - 101 DIV, LO, 0, 0
  - 110 REM, REM, 1, 1
  - 111 REM, REM, 0, 0
- ISSUE:
  - md_req_valid = 1 and request fields are stable until the transfer.
  - Transfer happens when md_req_valid && md_req_ready; go to WAIT.
  - kill before the transfer: go to IDLE, no request is sent.
  - kill in the same cycle as the transfer: go to DRAIN.
- WAIT:
  - On md_resp_valid, capture md_resp_result into wb_data and go to WB.
  - The MD unit has no response backpressure, so the capture must happen in that cycle.
  - kill, or kill coincident with md_resp_valid: go to DRAIN (or IDLE if the response arrived that cycle); result discarded.
- DRAIN:
  - Discard the next md_resp_valid, then go to IDLE.
  - stall_out = 1.
  - No new request is issued while the MD unit is busy.
- WB:
  - wb_valid = 1; wb_rd and wb_data held stable until wb_ready.
  - On wb_ready, go to IDLE and drive stall_out = 0 in that cycle so the pipeline advances exactly once; no re-issue of the same instruction.
  - kill in WB: drop the result and go to IDLE.
- stall_out = 1 in ISSUE, WAIT and DRAIN, and in WB while !wb_ready.
- rd = 0 is not special-cased; the register file ignores x0.
- Divide-by-zero and overflow results are produced by the MD unit, not here.
- Latency: MD latency + 2 cycles from dx_valid to wb_valid, when md_req_ready is already high.

Decomposition:
- Shared md constants package: MD_OP_* and MD_OUT_SEL_* encodings and widths, RV32M funct3 encodings, state encodings.
- One sub-module: vscale_md_decode, a combinational funct3 -> {op, out_sel, s1, s2} decoder.

Test Plan:
- MUL 7*6 (funct3 000, rd 5) -> one md request, op MUL, sel LO; wb_valid with rd 5 and data 0x0000002A; stall drops in the wb_ready cycle.
- MULHSU rs1 0xFFFFFFFE, rs2 3 -> s1 = 1, s2 = 0, sel HI; wb_data 0xFFFFFFFF.
- DIVU 100/7, then immediately REM -7, 2 -> wb_data 0x0000000E, then 0xFFFFFFFF; exactly two requests, no duplicate issue.
- kill 3 cycles after the request transfer -> DRAIN absorbs the response, wb_valid never asserts, stall held until the response plus 1 cycle, then the next instruction issues.
- wb_ready low for 4 cycles in WB -> wb_valid, wb_rd and wb_data stable; stall_out high throughout.
- reset asserted in WAIT -> next cycle IDLE with all outputs 0; the late md_resp_valid is ignored.
